// File: rtl/cache_pkg.sv
// Shared constants for the cache-side memory read path: bus widths, burst
// length and the one-hot state encoding used by the read arbiter.
package cache_pkg;

    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned BURST_BEATS = 8;

    // Beat counter width; the counter saturates rather than wrapping.
    localparam int unsigned BEAT_CNT_W  = 4;

    localparam int unsigned ARB_STATE_W = 3;
    localparam logic [ARB_STATE_W-1:0] ARB_IDLE = 3'b001;
    localparam logic [ARB_STATE_W-1:0] ARB_REQ  = 3'b010;
    localparam logic [ARB_STATE_W-1:0] ARB_RSP  = 3'b100;

    // True when a burst whose final beat arrives with 'cnt' earlier beats
    // does not have the expected length. Widened so cnt+1 cannot wrap.
    function automatic logic burst_len_bad(input logic [BEAT_CNT_W-1:0] cnt,
                                           input int unsigned beats);
        logic [31:0] total;
        total = {{(32 - BEAT_CNT_W){1'b0}}, cnt} + 32'd1;
        return total != beats;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way winner select: round-robin against the last owner, or a fixed
// preference for port 1 when round-robin is disabled.
module rr_pick2 #(
    parameter int RR_EN = 1
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner,
    output logic       any_req
);

    // Resolve the winner; a lone requester always wins.
    always_comb begin
        any_req = |req;
        if (req == 2'b11) begin
            winner = (RR_EN != 0) ? ~last_grant : 1'b1;
        end else begin
            winner = req[1];
        end
    end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Shares one burst-read memory port between the I-cache (port 0) and the
// D-cache (port 1). One burst is in flight at a time; the request address is
// registered so there is no combinational path from a cache to memory.
module mem_rd_arbiter
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = cache_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = cache_pkg::DATA_WIDTH,
    parameter int unsigned BURST_BEATS = cache_pkg::BURST_BEATS,
    parameter int          RR_EN       = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_rd_req_valid,
    input  logic [ADDR_WIDTH-1:0] m0_rd_req_addr,
    output logic                  m0_rd_req_ready,
    output logic                  m0_rd_rsp_valid,
    output logic [DATA_WIDTH-1:0] m0_rd_rsp_data,
    output logic                  m0_rd_rsp_last,
    input  logic                  m0_rd_rsp_ready,

    input  logic                  m1_rd_req_valid,
    input  logic [ADDR_WIDTH-1:0] m1_rd_req_addr,
    output logic                  m1_rd_req_ready,
    output logic                  m1_rd_rsp_valid,
    output logic [DATA_WIDTH-1:0] m1_rd_rsp_data,
    output logic                  m1_rd_rsp_last,
    input  logic                  m1_rd_rsp_ready,

    output logic                  to_mem_rd_req_valid,
    output logic [ADDR_WIDTH-1:0] to_mem_rd_req_addr,
    input  logic                  from_mem_rd_req_ready,
    input  logic                  from_mem_rd_rsp_valid,
    input  logic [DATA_WIDTH-1:0] from_mem_rd_rsp_data,
    input  logic                  from_mem_rd_rsp_last,
    output logic                  to_mem_rd_rsp_ready,

    output logic                  grant_id,
    output logic                  burst_err
);

    logic [ARB_STATE_W-1:0] state_q;
    logic                   grant_q;
    logic                   last_grant_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [BEAT_CNT_W-1:0]  cnt_q;
    logic                   err_q;

    logic                   winner;
    logic                   any_req;
    logic                   in_req;
    logic                   in_rsp;
    logic                   sel0;
    logic                   sel1;
    logic                   rsp_fire;

    rr_pick2 #(
        .RR_EN (RR_EN)
    ) u_pick (
        .req        ({m1_rd_req_valid, m0_rd_req_valid}),
        .last_grant (last_grant_q),
        .winner     (winner),
        .any_req    (any_req)
    );

    // State decode and the per-port routing selects.
    always_comb begin
        in_req   = (state_q == ARB_REQ);
        in_rsp   = (state_q == ARB_RSP);
        sel0     = in_rsp && !grant_q;
        sel1     = in_rsp && grant_q;
        rsp_fire = in_rsp && from_mem_rd_rsp_valid && to_mem_rd_rsp_ready;
    end

    // Output routing; everything not owned by the current phase is held at 0.
    always_comb begin
        to_mem_rd_req_valid = in_req;
        to_mem_rd_req_addr  = addr_q;
        m0_rd_req_ready     = in_req && !grant_q && from_mem_rd_req_ready;
        m1_rd_req_ready     = in_req && grant_q && from_mem_rd_req_ready;

        m0_rd_rsp_valid     = sel0 && from_mem_rd_rsp_valid;
        m0_rd_rsp_data      = sel0 ? from_mem_rd_rsp_data : '0;
        m0_rd_rsp_last      = sel0 && from_mem_rd_rsp_last;
        m1_rd_rsp_valid     = sel1 && from_mem_rd_rsp_valid;
        m1_rd_rsp_data      = sel1 ? from_mem_rd_rsp_data : '0;
        m1_rd_rsp_last      = sel1 && from_mem_rd_rsp_last;

        // Outside RSP memory beats are stalled, never consumed.
        to_mem_rd_rsp_ready = in_rsp && (grant_q ? m1_rd_rsp_ready : m0_rd_rsp_ready);

        grant_id            = grant_q;
        burst_err           = err_q;
    end

    // Burst sequencing: grant in IDLE, hand off the request in REQ, count
    // beats in RSP and check the burst length on the last one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (any_req) begin
                        grant_q <= winner;
                        addr_q  <= winner ? m1_rd_req_addr : m0_rd_req_addr;
                        state_q <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (from_mem_rd_req_ready) begin
                        cnt_q   <= '0;
                        state_q <= ARB_RSP;
                    end
                end
                ARB_RSP: begin
                    if (rsp_fire) begin
                        if (cnt_q != {BEAT_CNT_W{1'b1}}) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        if (from_mem_rd_rsp_last) begin
                            if (burst_len_bad(cnt_q, BURST_BEATS)) begin
                                err_q <= 1'b1;
                            end
                            last_grant_q <= grant_q;
                            grant_q      <= 1'b0;
                            state_q      <= ARB_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
